i2c_master_arbiter: RTL and testbench

- Shares one i2c_master instance between NUM_REQ independent requesters using round-robin arbitration.
- Takes each request (slave address, data byte, direction) over a valid/ready handshake and latches it.
- Drives the master's enable and operand inputs for the whole transfer, then returns a per-requester response pulse with read data and an error flag.
- Sits between the system-side register/command blocks and the i2c_master datapath.

---
 rtl/i2c_master_arbiter.sv | 174 +++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c_master between NUM_REQ
// requesters. Each request (address, byte, direction) is accepted over a
// valid/ready handshake, latched, and driven onto the master's operand
// inputs for the whole transfer. Completion comes back as a one-hot
// single-cycle response pulse carrying the read byte and an error flag.
//
// Handshake: a request is taken on a rising clock edge where
// req_valid_i[i] && req_ready_o[i]. Ready is combinational, raised only in
// IDLE, and only for the round-robin winner, so at most one bit is high.
//
// Optional transfer watchdog: define I2C_ARB_TIMEOUT_EN to build it. Without
// it XFER waits for m_done_i indefinitely and resp_err_o is constant 0.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int PRESC_WIDTH    = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 7,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk_i,
    input  logic                          a_rst_n_i,
    input  logic [PRESC_WIDTH-1:0]        prescale_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_dir_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic                          resp_err_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          m_en_o,
    output logic [PRESC_WIDTH-1:0]        m_prescale_o,
    output logic [ADDR_WIDTH-1:0]         m_slave_addr_o,
    output logic [DATA_WIDTH-1:0]         m_data_o,
    output logic                          m_dir_o,
    input  logic                          m_done_i,
    input  logic [DATA_WIDTH-1:0]         m_rdata_i
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, XFER, RESP, GAP} state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win;
    logic                found;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [GW-1:0]       gap_cnt;
    logic                to_hit;

    // Round-robin search: first valid requester after the last winner, with wrap.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win;

    // Ready is offered only in IDLE and only to the winner.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && found) begin
            req_ready_o = win_onehot;
        end
    end

    assign busy_o = (state != IDLE);

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          resp_err_q;

    // The watchdog trips in the XFER cycle where the count would reach the limit.
    assign to_hit     = (to_cnt + TW'(1)) == TW'(TIMEOUT_CYCLES);
    assign resp_err_o = resp_err_q;

    // Watchdog counter runs only in XFER; error flag is live for the RESP cycle only.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            to_cnt     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            to_cnt     <= (state == XFER) ? to_cnt + TW'(1) : '0;
            resp_err_q <= (state == XFER) && !m_done_i && to_hit;
        end
    end
`else
    // No watchdog: the comparison below is constant false.
    assign to_hit     = (TIMEOUT_CYCLES < 0);
    assign resp_err_o = 1'b0;
`endif

    // Main sequencer: accept, run the transfer, report, then hold off for the gap.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state          <= IDLE;
            ptr            <= IW'(NUM_REQ - 1);
            gap_cnt        <= '0;
            grant_o        <= '0;
            m_en_o         <= 1'b0;
            m_prescale_o   <= '0;
            m_slave_addr_o <= '0;
            m_data_o       <= '0;
            m_dir_o        <= 1'b0;
            resp_valid_o   <= '0;
            resp_data_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        m_prescale_o   <= prescale_i;
                        m_slave_addr_o <= req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
                        m_data_o       <= req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
                        m_dir_o        <= req_dir_i[win];
                        grant_o        <= win_onehot;
                        ptr            <= win;
                        m_en_o         <= 1'b1;
                        state          <= XFER;
                    end
                end
                XFER: begin
                    if (m_done_i) begin
                        m_en_o       <= 1'b0;
                        resp_valid_o <= grant_o;
                        resp_data_o  <= m_dir_o ? m_rdata_i : '0;
                        state        <= RESP;
                    end else if (to_hit) begin
                        m_en_o       <= 1'b0;
                        resp_valid_o <= grant_o;
                        resp_data_o  <= '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_o <= '0;
                    resp_data_o  <= '0;
                    grant_o      <= '0;
                    gap_cnt      <= '0;
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: directed requests, expected responses queued
// at handshake time and checked by an independent response monitor.
module tb_i2c_master_arbiter;

    localparam int NR  = 4;
    localparam int PW  = 16;
    localparam int DW  = 8;
    localparam int AW  = 7;
    localparam int GAP = 4;
    localparam int TO  = 50;
    localparam int EW  = NR + DW + 1;

    logic              clk;
    logic              a_rst_n_i;
    logic [PW-1:0]     prescale_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_dir_i;
    logic [NR-1:0]     resp_valid_o;
    logic [DW-1:0]     resp_data_o;
    logic              resp_err_o;
    logic [NR-1:0]     grant_o;
    logic              busy_o;
    logic              m_en_o;
    logic [PW-1:0]     m_prescale_o;
    logic [AW-1:0]     m_slave_addr_o;
    logic [DW-1:0]     m_data_o;
    logic              m_dir_o;
    logic              m_done_i;
    logic [DW-1:0]     m_rdata_i;

    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    i2c_master_arbiter #(
        .NUM_REQ(NR), .PRESC_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .a_rst_n_i(a_rst_n_i), .prescale_i(prescale_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_dir_i(req_dir_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .grant_o(grant_o), .busy_o(busy_o), .m_en_o(m_en_o),
        .m_prescale_o(m_prescale_o), .m_slave_addr_o(m_slave_addr_o),
        .m_data_o(m_data_o), .m_dir_o(m_dir_o),
        .m_done_i(m_done_i), .m_rdata_i(m_rdata_i)
    );

    // clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // response monitor: pops the scoreboard on every response pulse
    always @(negedge clk) begin
        if (a_rst_n_i) begin
            if (resp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got valid=%b data=%0h err=%b expected no response",
                             resp_valid_o, resp_data_o, resp_err_o);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("resp", {resp_valid_o, resp_data_o, resp_err_o}, e);
                end
            end else begin
                check("resp_quiet", {resp_data_o, resp_err_o}, '0);
            end
        end
    end

    // wait (bounded) for any ready bit, return the cycle it was seen
    task automatic wait_ready(output int hs);
        hs = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready_o != '0) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) check("ready_wait", 0, 1);
    endtask

    // present a request, check who is ready, queue the expected response
    task automatic issue(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic dir, input logic [DW-1:0] rd, input logic [PW-1:0] pre,
                         input logic err, input logic keep, output int hs);
        logic [NR-1:0] oh;
        oh = NR'(1) << r;
        req_addr_i[r*AW +: AW] = a;
        req_data_i[r*DW +: DW] = d;
        req_dir_i[r]           = dir;
        prescale_i             = pre;
        req_valid_i[r]         = 1'b1;
        wait_ready(hs);
        check("ready_onehot", req_ready_o, oh);
        exp_q.push_back({oh, (dir && !err) ? rd : 8'h00, err});
        @(posedge clk);
        #1;
        if (!keep) begin
            req_valid_i[r]         = 1'b0;
            req_addr_i[r*AW +: AW] = ~a;
            req_data_i[r*DW +: DW] = ~d;
            req_dir_i[r]           = ~dir;
            prescale_i             = ~pre;
        end
    endtask

    // play the master side: done pulse in cycle n after the handshake
    task automatic do_xfer(input int n, input logic [DW-1:0] rd, input logic [NR-1:0] g,
                           input logic [31:0] ops, output int en_cnt);
        en_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            if (c == n) begin
                m_done_i  = 1'b1;
                m_rdata_i = rd;
            end
            @(negedge clk);
            if (m_en_o) en_cnt++;
            if (c == 1) check("grant", grant_o, g);
            if (c == 1 || c == n)
                check("m_ops", {m_slave_addr_o, m_data_o, m_dir_o, m_prescale_o}, ops);
            @(posedge clk);
            #1;
            m_done_i  = 1'b0;
            m_rdata_i = 8'hEE;
        end
    endtask

    initial begin
        int hs;
        int prev;
        int en;
        a_rst_n_i   = 1'b0;
        prescale_i  = '0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        req_dir_i   = '0;
        m_done_i    = 1'b0;
        m_rdata_i   = 8'hEE;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {grant_o, busy_o, m_en_o, resp_valid_o, req_ready_o}, '0);
        check("rst_ops", {m_slave_addr_o, m_data_o, m_dir_o, m_prescale_o}, '0);
        @(posedge clk);
        #1;
        a_rst_n_i = 1'b1;

        // single write from requester 0, done 40 cycles after handshake
        issue(0, 7'h50, 8'hA5, 1'b0, 8'h00, 16'd100, 1'b0, 1'b0, hs);
        do_xfer(40, 8'h99, 4'b0001, {7'h50, 8'hA5, 1'b0, 16'd100}, en);
        check("t1_en_cycles", en, 40);
        @(negedge clk);
        check("t1_resp_en_busy", {m_en_o, busy_o}, 2'b01);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_gap_grant", {grant_o, busy_o, m_en_o}, {4'b0000, 1'b1, 1'b0});

        // read from requester 2
        @(posedge clk);
        #1;
        issue(2, 7'h1D, 8'h00, 1'b1, 8'h3C, 16'd100, 1'b0, 1'b0, hs);
        do_xfer(5, 8'h3C, 4'b0100, {7'h1D, 8'h00, 1'b1, 16'd100}, en);
        check("t2_en_cycles", en, 5);

        // spurious done during GAP, then during IDLE
        @(posedge clk);
        #1;
        m_done_i = 1'b1;
        @(negedge clk);
        check("gap_spurious", {busy_o, m_en_o, grant_o}, {1'b1, 1'b0, 4'b0000});
        @(posedge clk);
        #1;
        m_done_i = 1'b0;
        repeat (GAP + 2) @(posedge clk);
        #1;
        m_done_i = 1'b1;
        @(negedge clk);
        check("idle_spurious", {busy_o, m_en_o, grant_o}, '0);
        @(posedge clk);
        #1;
        m_done_i = 1'b0;
        @(negedge clk);
        check("idle_after_spurious", {busy_o, m_en_o}, 2'b00);

        // reset in the middle of a transfer
        @(posedge clk);
        #1;
        issue(1, 7'h22, 8'h11, 1'b0, 8'h00, 16'd7, 1'b0, 1'b0, hs);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_en", {m_en_o, grant_o}, {1'b1, 4'b0010});
        @(posedge clk);
        #1;
        a_rst_n_i = 1'b0;
        #1;
        check("async_rst", {m_en_o, grant_o, busy_o}, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        a_rst_n_i = 1'b1;

        // round robin with everybody valid; requester 3 reads
        for (int r = 0; r < NR; r++) begin
            req_addr_i[r*AW +: AW] = 7'h10 + 7'(r);
            req_data_i[r*DW +: DW] = 8'hA0 + 8'(r);
            req_dir_i[r]           = (r == 3);
        end
        prescale_i  = 16'd100;
        req_valid_i = '1;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            int r;
            r = g % NR;
            issue(r, 7'h10 + 7'(r), 8'hA0 + 8'(r), (r == 3), 8'h70 + 8'(r), 16'd100,
                  1'b0, 1'b1, hs);
            if (g > 0) check("rr_spacing", hs - prev, 12 + GAP);
            prev = hs;
            if (g == 4) req_valid_i = '0;
            do_xfer(10, 8'h70 + 8'(r), NR'(1) << r,
                    {7'h10 + 7'(r), 8'hA0 + 8'(r), (r == 3), 16'd100}, en);
            check("rr_en_cycles", en, 10);
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // watchdog: no done at all, then done exactly at the limit
        @(posedge clk);
        #1;
        issue(0, 7'h33, 8'h44, 1'b0, 8'h00, 16'd9, 1'b1, 1'b0, hs);
        en = -1;
        for (int c = 1; c <= TO + 10; c++) begin
            @(negedge clk);
            if (resp_valid_o != '0) begin
                en = c;
                break;
            end
        end
        check("to_latency", en, TO + 1);
        @(posedge clk);
        #1;
        issue(0, 7'h33, 8'h44, 1'b0, 8'h00, 16'd9, 1'b0, 1'b0, hs);
        do_xfer(TO, 8'h55, 4'b0001, {7'h33, 8'h44, 1'b0, 16'd9}, en);
        check("to_done_wins_en", en, TO);
`endif

        repeat (10) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
